// File: rtl/trk_multitap_correlator_engine.sv
// trk_multitap_correlator_engine
//   Multi-tap tracking correlator fed by carrier-wiped I/Q samples. After an
//   acquisition delay (skipped samples), each tap accumulates +/-I and +/-Q
//   (sign chosen by that tap's code chip) over a programmable length. The
//   result is dumped to registers and offered with a valid/ready handshake.
//   Single-shot mode waits for i_rearm; continuous mode integrates back to
//   back and stalls the input only if the previous dump is still unread.
// Ports
//   axis_aclk / axis_aresetn   clock / synchronous active-high reset
//   i_start, i_stop, i_rearm   control pulses (i_stop has top priority)
//   i_continuous               back-to-back integrations
//   i_acq_delay, i_corr_length skip count and integration length (live)
//   s_sample_*                 {I,Q} sample stream, i_code_chips qualified with it
//   o_sample_count             samples accepted since i_start
//   o_acc_i/o_acc_q, o_dump_valid, i_dump_ready   dump result handshake
//   o_busy, o_overflow         SKIP/RUN indicator, sticky saturation flag

// Per-tap next-sum: acc + (chip ? x : -x), saturated, for I and Q.
module trk_multitap_correlator_tap #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32
) (
    input  logic [ACC_W-1:0]    acc_i_i,
    input  logic [ACC_W-1:0]    acc_q_i,
    input  logic [SAMPLE_W-1:0] x_i_i,
    input  logic [SAMPLE_W-1:0] x_q_i,
    input  logic                chip_i,
    output logic [ACC_W-1:0]    sum_i_o,
    output logic [ACC_W-1:0]    sum_q_o,
    output logic                sat_o
);
    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] term_i, term_q;
    logic [ACC_W:0]   raw_i, raw_q;
    logic             sat_i, sat_q;

    always_comb begin
        // Extend before negating so the most negative sample negates exactly.
        term_i = {{(ACC_W-SAMPLE_W){x_i_i[SAMPLE_W-1]}}, x_i_i};
        term_q = {{(ACC_W-SAMPLE_W){x_q_i[SAMPLE_W-1]}}, x_q_i};
        if (!chip_i) begin
            term_i = -term_i;
            term_q = -term_q;
        end
        // One guard bit: overflow when the two top bits disagree.
        raw_i   = {acc_i_i[ACC_W-1], acc_i_i} + {term_i[ACC_W-1], term_i};
        raw_q   = {acc_q_i[ACC_W-1], acc_q_i} + {term_q[ACC_W-1], term_q};
        sat_i   = raw_i[ACC_W] ^ raw_i[ACC_W-1];
        sat_q   = raw_q[ACC_W] ^ raw_q[ACC_W-1];
        sum_i_o = sat_i ? (raw_i[ACC_W] ? MINV : MAXV) : raw_i[ACC_W-1:0];
        sum_q_o = sat_q ? (raw_q[ACC_W] ? MINV : MAXV) : raw_q[ACC_W-1:0];
        sat_o   = sat_i | sat_q;
    end
endmodule

module trk_multitap_correlator_engine #(
    parameter int NUM_TAPS = 4,
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 48
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_rearm,
    input  logic                      i_continuous,
    input  logic [CNT_W-1:0]          i_acq_delay,
    input  logic [CNT_W-1:0]          i_corr_length,
    input  logic                      s_sample_tvalid,
    output logic                      s_sample_tready,
    input  logic [2*SAMPLE_W-1:0]     s_sample_tdata,
    input  logic [NUM_TAPS-1:0]       i_code_chips,
    output logic [CNT_W-1:0]          o_sample_count,
    output logic [NUM_TAPS*ACC_W-1:0] o_acc_i,
    output logic [NUM_TAPS*ACC_W-1:0] o_acc_q,
    output logic                      o_dump_valid,
    input  logic                      i_dump_ready,
    output logic                      o_busy,
    output logic                      o_overflow
);
    typedef enum logic [2:0] {S_IDLE, S_SKIP, S_RUN, S_DUMP, S_ARMED} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d, pts_q, pts_d;
    logic [NUM_TAPS-1:0][ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [NUM_TAPS-1:0][ACC_W-1:0]  dmp_i_q, dmp_i_d, dmp_q_q, dmp_q_d;
    logic                            dv_q, dv_d, ovf_q, ovf_d;
    logic [NUM_TAPS-1:0][ACC_W-1:0]  sum_i, sum_q;
    logic [NUM_TAPS-1:0]             sat;
    logic [CNT_W-1:0]                len_eff, cnt_inc;
    logic                            last, hs, take;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        trk_multitap_correlator_tap #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_tap (
            .acc_i_i (acc_i_q[k]),
            .acc_q_i (acc_q_q[k]),
            .x_i_i   (s_sample_tdata[2*SAMPLE_W-1:SAMPLE_W]),
            .x_q_i   (s_sample_tdata[SAMPLE_W-1:0]),
            .chip_i  (i_code_chips[k]),
            .sum_i_o (sum_i[k]),
            .sum_q_o (sum_q[k]),
            .sat_o   (sat[k])
        );
    end

    always_comb begin
        len_eff = (i_corr_length == '0) ? CNT_W'(1) : i_corr_length;
        // >= so a length shortened mid-integration still terminates.
        last    = (pts_q >= len_eff - CNT_W'(1));
        cnt_inc = cnt_q + CNT_W'(1);
        hs      = dv_q & i_dump_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        pts_d   = pts_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        dmp_i_d = dmp_i_q;
        dmp_q_d = dmp_q_q;
        dv_d    = hs ? 1'b0 : dv_q;
        ovf_d   = ovf_q;
        s_sample_tready = 1'b0;
        take    = 1'b0;

        case (state_q)
            S_IDLE: begin
                s_sample_tready = 1'b1;
                if (i_start) begin
                    state_d = (i_acq_delay == '0) ? S_RUN : S_SKIP;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    pts_d   = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                end
            end
            S_SKIP: begin
                // Delay may be reprogrammed live; leave as soon as it is met.
                if (cnt_q == i_acq_delay) begin
                    state_d = S_RUN;
                end else begin
                    s_sample_tready = 1'b1;
                    if (s_sample_tvalid) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == i_acq_delay) state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Hold the closing sample back until the previous dump is read.
                s_sample_tready = !(last && dv_q);
                take = s_sample_tvalid && s_sample_tready;
                if (take) begin
                    cnt_d = cnt_inc;
                    if (|sat) ovf_d = 1'b1;
                    if (last) begin
                        dmp_i_d = sum_i;
                        dmp_q_d = sum_q;
                        acc_i_d = '0;
                        acc_q_d = '0;
                        pts_d   = '0;
                        dv_d    = 1'b1;
                        if (!i_continuous) state_d = S_DUMP;
                    end else begin
                        acc_i_d = sum_i;
                        acc_q_d = sum_q;
                        pts_d   = pts_q + CNT_W'(1);
                    end
                end
            end
            S_DUMP: begin
                if (hs) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (i_rearm) begin
                    state_d = S_RUN;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    pts_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pts_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
            dmp_i_d = '0;
            dmp_q_d = '0;
            dv_d    = 1'b0;
            ovf_d   = 1'b0;
            s_sample_tready = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pts_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            dmp_i_q <= '0;
            dmp_q_q <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pts_q   <= pts_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            dmp_i_q <= dmp_i_d;
            dmp_q_q <= dmp_q_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_sample_count = cnt_q;
    assign o_acc_i        = dmp_i_q;
    assign o_acc_q        = dmp_q_q;
    assign o_dump_valid   = dv_q;
    assign o_busy         = (state_q == S_SKIP) || (state_q == S_RUN);
    assign o_overflow     = ovf_q;
endmodule

// File: tb/tb_trk_multitap_correlator_engine.sv
// Bench for trk_multitap_correlator_engine: directed scenarios plus random
// episodes, checked against a transaction-level model that groups accepted
// samples into integrations by plain arithmetic.
module tb_trk_multitap_correlator_engine;
    localparam int NT = 4, SW = 16, AW = 17, CW = 48;
    localparam longint AMAX = 65535, AMIN = -65536;

    logic            clk = 0, rst = 1;
    logic            start = 0, stop = 0, rearm = 0, cont = 0;
    logic [CW-1:0]   acq_delay = '0, corr_length = '0;
    logic            tvalid = 0, tready;
    logic [2*SW-1:0] tdata = '0;
    logic [NT-1:0]   chips = '0;
    logic [CW-1:0]   count;
    logic [NT*AW-1:0] acc_i, acc_q;
    logic            dv, dready = 0, busy, ovf;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    trk_multitap_correlator_engine #(.NUM_TAPS(NT), .SAMPLE_W(SW), .ACC_W(AW), .CNT_W(CW)) dut (
        .axis_aclk(clk), .axis_aresetn(rst), .i_start(start), .i_stop(stop), .i_rearm(rearm),
        .i_continuous(cont), .i_acq_delay(acq_delay), .i_corr_length(corr_length),
        .s_sample_tvalid(tvalid), .s_sample_tready(tready), .s_sample_tdata(tdata),
        .i_code_chips(chips), .o_sample_count(count), .o_acc_i(acc_i), .o_acc_q(acc_q),
        .o_dump_valid(dv), .i_dump_ready(dready), .o_busy(busy), .o_overflow(ovf)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint tap(input logic [NT*AW-1:0] v, input int k);
        logic [AW-1:0] s;
        s = v[k*AW +: AW];
        return longint'($signed(s));
    endfunction

    function automatic longint satc(input longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic   mactive = 0, movf = 0, pend_dv = 0;
    longint mn = 0;
    longint macc_i[NT], macc_q[NT];
    longint eq_i[$], eq_q[$];

    always @(negedge clk) begin
        longint xi, xq, t, s, leff, j;
        if (pend_dv) begin
            chk("dump_latency", dv, 1);
            pend_dv = 0;
        end
        if (rst || stop) begin
            mactive = 0;
            eq_i.delete();
            eq_q.delete();
        end else begin
            if (dv && dready) begin
                if (eq_i.size() < NT) chk("dump_unexpected", 1, 0);
                else begin
                    for (int k = 0; k < NT; k++) begin
                        chk($sformatf("dump_i%0d", k), tap(acc_i, k), eq_i.pop_front());
                        chk($sformatf("dump_q%0d", k), tap(acc_q, k), eq_q.pop_front());
                    end
                    chk("dump_count", longint'(count), mn);
                    chk("dump_ovf", ovf, movf);
                end
            end
            if (tvalid && tready && mactive) begin
                if (mn >= longint'(acq_delay)) begin
                    xi = longint'($signed(tdata[2*SW-1:SW]));
                    xq = longint'($signed(tdata[SW-1:0]));
                    for (int k = 0; k < NT; k++) begin
                        t = chips[k] ? xi : -xi;
                        s = macc_i[k] + t;
                        if (s != satc(s)) movf = 1;
                        macc_i[k] = satc(s);
                        t = chips[k] ? xq : -xq;
                        s = macc_q[k] + t;
                        if (s != satc(s)) movf = 1;
                        macc_q[k] = satc(s);
                    end
                    leff = (corr_length == 0) ? 1 : longint'(corr_length);
                    j = mn - longint'(acq_delay);
                    if ((j + 1) % leff == 0) begin
                        for (int k = 0; k < NT; k++) begin
                            eq_i.push_back(macc_i[k]);
                            eq_q.push_back(macc_q[k]);
                            macc_i[k] = 0;
                            macc_q[k] = 0;
                        end
                        pend_dv = 1;
                    end
                end
                mn++;
            end
            if (start && !mactive) begin
                mactive = 1;
                mn = 0;
                movf = 0;
                for (int k = 0; k < NT; k++) begin
                    macc_i[k] = 0;
                    macc_q[k] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(); start = 1; tick(); start = 0; endtask
    task automatic pulse_stop();  stop = 1;  tick(); stop = 0;  endtask
    task automatic pulse_rearm(); rearm = 1; tick(); rearm = 0; endtask

    task automatic send(input int i, input int q, input logic [NT-1:0] ch);
        logic ok;
        int   n;
        tdata  = {16'(i), 16'(q)};
        chips  = ch;
        tvalid = 1;
        n = 0;
        forever begin
            @(negedge clk);
            ok = tready;
            tick();
            if (ok) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        tvalid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_cnt;
        tick(3);
        rst = 0;
        @(negedge clk);
        chk("rst_tready", tready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dv", dv, 0);
        chk("rst_count", count, 0);
        chk("rst_acc", acc_i | acc_q, 0);
        tick();

        // Single-shot: 3 skipped, 4 integrated
        acq_delay = 3; corr_length = 4; cont = 0; dready = 1;
        pulse_start();
        @(negedge clk);
        chk("skip_busy", busy, 1);
        tick();
        for (int n = 0; n < 7; n++) send(100, 100, 4'b0101);
        tick(2);
        @(negedge clk);
        chk("ss_count", count, 7);
        chk("ss_armed_tready", tready, 0);
        chk("ss_armed_busy", busy, 0);
        chk("ss_dv_done", dv, 0);
        chk("ss_tap0_i", tap(acc_i, 0), 400);
        chk("ss_tap1_q", tap(acc_q, 1), -400);
        chk("ss_tap2_i", tap(acc_i, 2), 400);
        chk("ss_tap3_i", tap(acc_i, 3), -400);
        tick();

        // Re-arm without new skip
        pulse_rearm();
        for (int n = 0; n < 4; n++) send(-50, -50, 4'b1111);
        tick(2);
        @(negedge clk);
        chk("rearm_count", count, 11);
        for (int k = 0; k < NT; k++) begin
            chk($sformatf("rearm_i%0d", k), tap(acc_i, k), -200);
            chk($sformatf("rearm_q%0d", k), tap(acc_q, k), -200);
        end
        tick();

        // Stop together with rearm in ARMED
        stop = 1; rearm = 1; tick(); stop = 0; rearm = 0;
        @(negedge clk);
        chk("stop_rearm_tready", tready, 1);
        chk("stop_rearm_busy", busy, 0);
        chk("stop_rearm_dv", dv, 0);
        tick();

        // Continuous with blocked consumer
        acq_delay = 0; corr_length = 2; cont = 1; dready = 0;
        pulse_start();
        tvalid = 1; tdata = $urandom; chips = 4'($urandom);
        acc_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tready) acc_cnt++;
            tick();
            tdata = $urandom; chips = 4'($urandom);
        end
        @(negedge clk);
        chk("cont_accepts", acc_cnt, 3);
        chk("cont_stall_tready", tready, 0);
        chk("cont_dv_held", dv, 1);
        tick();
        dready = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            tdata = $urandom; chips = 4'($urandom);
        end
        tvalid = 0;
        tick(4);
        chk("cont_drained", eq_i.size(), 0);
        pulse_stop();

        // Saturation
        acq_delay = 0; corr_length = 3; cont = 0; dready = 1;
        pulse_start();
        for (int n = 0; n < 3; n++) send(32767, -32768, 4'b1111);
        tick(2);
        @(negedge clk);
        chk("sat_ovf", ovf, 1);
        chk("sat_i_max", tap(acc_i, 0), AMAX);
        chk("sat_q_min", tap(acc_q, 0), AMIN);
        tick();
        pulse_start();
        @(negedge clk);
        chk("sat_ovf_kept", ovf, 1);
        tick();
        pulse_stop();
        pulse_start();
        @(negedge clk);
        chk("start_clears_ovf", ovf, 0);
        tick();
        pulse_stop();

        // len=0 behaves as len=1, delay=0 integrates first sample
        acq_delay = 0; corr_length = 0; cont = 1; dready = 1;
        pulse_start();
        for (int n = 0; n < 4; n++) send($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000, 4'($urandom));
        tick(3);
        chk("len0_drained", eq_i.size(), 0);
        pulse_stop();

        // Reset mid-RUN
        acq_delay = 0; corr_length = 10; cont = 0;
        pulse_start();
        send(7, 7, 4'b1111);
        send(7, 7, 4'b1111);
        rst = 1; tick(); rst = 0;
        @(negedge clk);
        chk("midrst_tready", tready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_dv", dv, 0);
        chk("midrst_acc", acc_i | acc_q, 0);
        tick();

        // Random episodes
        for (int e = 0; e < 8; e++) begin
            acq_delay = CW'($urandom_range(0, 4));
            corr_length = CW'($urandom_range(0, 5));
            cont = 1'($urandom);
            pulse_start();
            for (int c = 0; c < 80; c++) begin
                tvalid = 1'($urandom);
                if ($urandom_range(0, 3) == 0) tdata = $urandom;
                else tdata = {16'($urandom_range(0, 4000) - 2000), 16'($urandom_range(0, 4000) - 2000)};
                chips  = 4'($urandom);
                dready = ($urandom_range(0, 9) < 7);
                rearm  = ($urandom_range(0, 4) == 0);
                tick();
            end
            tvalid = 0; rearm = 0; dready = 1;
            tick(5);
            chk("rand_drained", eq_i.size(), 0);
            pulse_stop();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
